param_reg_file_sb: RTL and testbench
====================================

// Module: param_reg_file_sb
// PURPOSE
//   Parametrised general-purpose register file with integrated scoreboard and write-back bypass.
//   Successor to the fixed 8x32 NormalRegs block: N read ports (operand A/B + BR target by default).
//   Two independent write-back ports (ALU, ID) instead of a 2:1 write mux.
//   Per-register pending bits let the decoder stall on RAW hazards.
//   Sits between ID (reads, reserve) and write-back (ALU/ID results).
// PARAMETERS
//   DATA_W   32  register width in bits
//   NUM_REGS 8   register count, power of 2, >=2
//   NUM_RD   3   read ports; port 0 = operand A, 1 = operand B, 2 = BR target
//   BYPASS   1   1 = same-cycle write data forwarded to read ports; 0 = read returns stored value
//   localparam AW = $clog2(NUM_REGS), CW = $clog2(NUM_REGS+1)
// PORTS
//   clk          in   1              single clock, all state updates on posedge
//   rst_n        in   1              synchronous, active-low reset
//   rd_addr      in   NUM_RD*AW      packed read addresses, port i at [i*AW +: AW]
//   rd_data      out  NUM_RD*DATA_W  packed read data, combinational
//   rd_ready     out  NUM_RD         1 = rd_data valid (reg not pending, or bypassed)
//   wr_en        in   2              write enables; bit 0 = ALU port, bit 1 = ID port
//   wr_addr      in   2*AW           packed write addresses
//   wr_data      in   2*DATA_W       packed write data
//   rsv_en       in   1              reserve destination for an issued instruction
//   rsv_addr     in   AW             register to mark pending
//   pending      out  NUM_REGS       scoreboard bit per register (registered)
//   pending_cnt  out  CW             popcount of pending
//   err_dbl_rsv  out  1              sticky: reserve of an already-pending register
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): all registers <= 0, pending <= 0, err_dbl_rsv <= 0.
//     Writes/reserves presented in a reset cycle are dropped. Outputs after reset:
//     rd_data=0, rd_ready=all 1, pending_cnt=0, err_dbl_rsv=0.
//   Reads: zero-latency combinational. rd_ready[i] = ~pending[rd_addr_i], except bypass hit.
//   Writes: take effect at posedge; visible on rd_data from the next cycle (BYPASS=0).
//   Both write ports, same address, same cycle: ALU port (bit 0) wins; ID data discarded.
//   Different addresses: both written same cycle.
//   BYPASS=1: if any wr_en[k] && wr_addr_k==rd_addr_i, rd_data_i = that wr_data (ALU priority),
//     rd_ready[i]=1 regardless of pending.
//   Scoreboard, per register r, next-state priority highest first:
//     reset -> 0; rsv_en && rsv_addr==r -> 1; any wr_en[k] && wr_addr_k==r -> 0; else hold.
//   Reserve + write to same reg in one cycle: data is written, pending ends 1 (new producer owns it).
//   Write to a non-pending register: legal (init/moves), data written, pending stays 0, no error.
//   rsv_en to a register with pending=1 (and no same-cycle write clearing it): err_dbl_rsv <= 1,
//     pending stays 1; sticky until reset.
//   pending_cnt: combinational popcount of registered pending vector; range 0..NUM_REGS.
//   No register is hardwired to zero.
// STRUCTURE
//   Shared package: wb_port_e enum (WB_ALU=0, WB_ID=1), NUM_WB_PORTS=2 constant.
//   Sub-module reg_scoreboard: pending vector, priority update, err_dbl_rsv, pending_cnt.
//   Top holds the storage array, write-port arbitration and read/bypass muxes.
// TESTING
//   Reset: preload r3=0xDEADBEEF, assert rst_n=0 one cycle -> all rd_data=0, pending=0, err=0.
//   Dual write: ALU r1=0x11, ID r2=0x22 same cycle -> next cycle r1=0x11, r2=0x22.
//   Write conflict: ALU r5=0xAAAA, ID r5=0x5555 -> r5=0xAAAA.
//   Bypass: BYPASS=1, wr ALU r4=0x1234, rd port0 addr 4 same cycle -> rd_data0=0x1234, ready=1;
//     BYPASS=0 -> old r4 value shown.
//   Scoreboard: rsv r6 -> pending[6]=1, cnt=1, rd_ready for r6=0; ID writes r6=0x77 ->
//     pending[6]=0, cnt=0; rsv r6 + ALU write r6 same cycle -> r6 written, pending[6]=1.
//   Double reserve: rsv r2 twice without write -> err_dbl_rsv=1, held until rst_n=0.

Source files
------------

// File: rtl/param_reg_file_sb_pkg.sv
// Shared types and constants for the parametrised register file with scoreboard.
package param_reg_file_sb_pkg;

  localparam int NUM_WB_PORTS = 2;

  // Write-back port identifiers; ALU has priority on same-address conflicts.
  typedef enum logic [0:0] {
    WB_ALU = 1'b0,
    WB_ID  = 1'b1
  } wb_port_e;

endpackage

// File: rtl/param_reg_file_sb_if.sv
// Bus bundle between decode/write-back (master) and the register file (slave).
interface param_reg_file_sb_if
  import param_reg_file_sb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 3
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(NUM_REGS + 1);

  logic [NUM_RD*AW-1:0]           rd_addr;
  logic [NUM_RD*DATA_W-1:0]       rd_data;
  logic [NUM_RD-1:0]              rd_ready;
  logic [NUM_WB_PORTS-1:0]        wr_en;
  logic [NUM_WB_PORTS*AW-1:0]     wr_addr;
  logic [NUM_WB_PORTS*DATA_W-1:0] wr_data;
  logic                           rsv_en;
  logic [AW-1:0]                  rsv_addr;
  logic [NUM_REGS-1:0]            pending;
  logic [CW-1:0]                  pending_cnt;
  logic                           err_dbl_rsv;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_ready, pending, pending_cnt, err_dbl_rsv
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_ready, pending, pending_cnt, err_dbl_rsv
  );

endinterface

// File: rtl/param_reg_file_sb_reg_scoreboard.sv
// Per-register pending bits, sticky double-reserve error and pending popcount.
module reg_scoreboard
  import param_reg_file_sb_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int AW       = $clog2(NUM_REGS),
  parameter int CW       = $clog2(NUM_REGS + 1)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_WB_PORTS-1:0]             wr_en,
  input  logic [NUM_WB_PORTS-1:0][AW-1:0]     wr_addr,
  input  logic                                rsv_en,
  input  logic [AW-1:0]                       rsv_addr,
  output logic [NUM_REGS-1:0]                 pending,
  output logic [CW-1:0]                       pending_cnt,
  output logic                                err_dbl_rsv
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] wr_clr;
  logic                err_q, err_d;

  // Registers targeted by any write-back port this cycle.
  always_comb begin
    wr_clr = '0;
    for (int k = 0; k < NUM_WB_PORTS; k++)
      if (wr_en[k]) wr_clr[wr_addr[k]] = 1'b1;
  end

  // Reserve beats write-back clear, so a new producer keeps ownership.
  always_comb begin
    pending_d = pending_q & ~wr_clr;
    if (rsv_en) pending_d[rsv_addr] = 1'b1;
    err_d = err_q | (rsv_en & pending_q[rsv_addr] & ~wr_clr[rsv_addr]);
  end

  // Scoreboard state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  // Popcount of the registered pending vector.
  always_comb begin
    pending_cnt = '0;
    for (int r = 0; r < NUM_REGS; r++)
      pending_cnt = pending_cnt + {{(CW-1){1'b0}}, pending_q[r]};
  end

  assign pending     = pending_q;
  assign err_dbl_rsv = err_q;

endmodule

// File: rtl/param_reg_file_sb.sv
// Register file: storage, dual write-back with ALU priority, read ports with optional bypass.
module param_reg_file_sb
  import param_reg_file_sb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 3,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  param_reg_file_sb_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(NUM_REGS + 1);

  logic [NUM_WB_PORTS-1:0]             wr_en;
  logic [NUM_WB_PORTS-1:0][AW-1:0]     wa;
  logic [NUM_WB_PORTS-1:0][DATA_W-1:0] wd;
  logic [NUM_RD-1:0][AW-1:0]           ra;
  logic [NUM_RD-1:0][DATA_W-1:0]       rd_data_w;
  logic [NUM_RD-1:0]                   rd_ready_w;
  logic [NUM_REGS-1:0]                 pending_w;
  logic [NUM_REGS-1:0][DATA_W-1:0]     mem_q, mem_d;

  assign wr_en = bus.wr_en;
  assign wa    = bus.wr_addr;
  assign wd    = bus.wr_data;
  assign ra    = bus.rd_addr;

  // Apply higher ports first so the ALU port (index 0) lands last and wins conflicts.
  always_comb begin
    mem_d = mem_q;
    for (int k = NUM_WB_PORTS - 1; k >= 0; k--)
      if (wr_en[k]) mem_d[wa[k]] = wd[k];
  end

  // Storage array; writes in a reset cycle are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) mem_q <= '0;
    else        mem_q <= mem_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic hit_alu, hit_id;
    assign hit_alu = (BYPASS != 0) && wr_en[WB_ALU] && (wa[WB_ALU] == ra[i]);
    assign hit_id  = (BYPASS != 0) && wr_en[WB_ID]  && (wa[WB_ID]  == ra[i]);
    assign rd_data_w[i]  = hit_alu ? wd[WB_ALU] :
                           hit_id  ? wd[WB_ID]  : mem_q[ra[i]];
    assign rd_ready_w[i] = hit_alu | hit_id | ~pending_w[ra[i]];
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW),
    .CW       (CW)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wa),
    .rsv_en      (bus.rsv_en),
    .rsv_addr    (bus.rsv_addr),
    .pending     (pending_w),
    .pending_cnt (bus.pending_cnt),
    .err_dbl_rsv (bus.err_dbl_rsv)
  );

  assign bus.rd_data  = rd_data_w;
  assign bus.rd_ready = rd_ready_w;
  assign bus.pending  = pending_w;

endmodule

// File: tb/tb_param_reg_file_sb.sv
// Bench: two DUTs (bypass on/off) share stimulus and are checked against a reference model.
module tb_param_reg_file_sb;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int ND = 3;
  localparam int AW = $clog2(NR);
  localparam int CW = $clog2(NR + 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [ND*AW-1:0] rd_addr;
  logic [1:0]       wr_en;
  logic [2*AW-1:0]  wr_addr;
  logic [2*DW-1:0]  wr_data;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;

  param_reg_file_sb_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(ND)) b1 ();
  param_reg_file_sb_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(ND)) b0 ();

  assign b1.rd_addr = rd_addr;  assign b0.rd_addr = rd_addr;
  assign b1.wr_en   = wr_en;    assign b0.wr_en   = wr_en;
  assign b1.wr_addr = wr_addr;  assign b0.wr_addr = wr_addr;
  assign b1.wr_data = wr_data;  assign b0.wr_data = wr_data;
  assign b1.rsv_en  = rsv_en;   assign b0.rsv_en  = rsv_en;
  assign b1.rsv_addr = rsv_addr; assign b0.rsv_addr = rsv_addr;

  param_reg_file_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(ND), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));
  param_reg_file_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(ND), .BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave));

  // Reference model state.
  logic [DW-1:0] m_mem [NR];
  logic [NR-1:0] m_pend;
  logic          m_err;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int wa(input int k);
    logic [2*AW-1:0] v;
    v = wr_addr;
    return int'(v[k*AW +: AW]);
  endfunction

  function automatic logic [DW-1:0] wdat(input int k);
    logic [2*DW-1:0] v;
    v = wr_data;
    return v[k*DW +: DW];
  endfunction

  // Reads: ALU write to the address beats ID write, which beats stored value.
  function automatic logic [DW:0] exp_rd(input int a, input bit bp);
    if (bp && wr_en[0] && wa(0) == a) return {1'b1, wdat(0)};
    if (bp && wr_en[1] && wa(1) == a) return {1'b1, wdat(1)};
    return {~m_pend[a], m_mem[a]};
  endfunction

  task automatic check_outputs();
    logic [DW:0] e;
    int a;
    for (int i = 0; i < ND; i++) begin
      a = int'(rd_addr[i*AW +: AW]);
      e = exp_rd(a, 1'b1);
      chk($sformatf("byp_rd%0d", i), 64'(b1.rd_data[i*DW +: DW]), 64'(e[DW-1:0]));
      chk($sformatf("byp_rdy%0d", i), 64'(b1.rd_ready[i]), 64'(e[DW]));
      e = exp_rd(a, 1'b0);
      chk($sformatf("nob_rd%0d", i), 64'(b0.rd_data[i*DW +: DW]), 64'(e[DW-1:0]));
      chk($sformatf("nob_rdy%0d", i), 64'(b0.rd_ready[i]), 64'(e[DW]));
    end
    chk("pending", 64'(b1.pending), 64'(m_pend));
    chk("pending_nob", 64'(b0.pending), 64'(m_pend));
    chk("pend_cnt", 64'(b1.pending_cnt), 64'($countones(m_pend)));
    chk("err", 64'(b1.err_dbl_rsv), 64'(m_err));
  endtask

  task automatic model_update();
    bit wr_hit;
    if (!rst_n) begin
      foreach (m_mem[r]) m_mem[r] = '0;
      m_pend = '0;
      m_err  = 1'b0;
    end else begin
      wr_hit = (wr_en[0] && wa(0) == int'(rsv_addr)) || (wr_en[1] && wa(1) == int'(rsv_addr));
      if (rsv_en && m_pend[rsv_addr] && !wr_hit) m_err = 1'b1;
      if (wr_en[1]) begin m_mem[wa(1)] = wdat(1); m_pend[wa(1)] = 1'b0; end
      if (wr_en[0]) begin m_mem[wa(0)] = wdat(0); m_pend[wa(0)] = 1'b0; end
      if (rsv_en) m_pend[rsv_addr] = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    wr_en = '0; rsv_en = 1'b0;
  endtask

  task automatic set_wr(input int k, input int a, input logic [DW-1:0] d);
    wr_en[k] = 1'b1;
    wr_addr[k*AW +: AW] = AW'(a);
    wr_data[k*DW +: DW] = d;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
    idle();
    foreach (m_mem[r]) m_mem[r] = '0;
    m_pend = '0; m_err = 1'b0;
    @(posedge clk); #1;
    step();

    // Preload r3, then reset clears it; write during reset is dropped.
    rst_n = 1'b1;
    set_wr(0, 3, 32'hDEADBEEF); step(); idle();
    set_rd(0, 3); #1;
    chk("preload_r3", 64'(b0.rd_data[DW-1:0]), 64'h0000_0000_DEAD_BEEF);
    rst_n = 1'b0; set_wr(1, 7, 32'hCAFE); step(); idle(); rst_n = 1'b1;
    set_rd(1, 7); #1;
    chk("rst_r3", 64'(b1.rd_data[DW-1:0]), 64'h0);
    chk("rst_r7", 64'(b1.rd_data[DW +: DW]), 64'h0);
    chk("rst_ready", 64'(b1.rd_ready), 64'h7);
    chk("rst_cnt", 64'(b1.pending_cnt), 64'h0);
    step();

    // Dual write to different registers.
    set_wr(0, 1, 32'h11); set_wr(1, 2, 32'h22); step(); idle();
    set_rd(0, 1); set_rd(1, 2); #1;
    chk("dual_r1", 64'(b0.rd_data[DW-1:0]), 64'h11);
    chk("dual_r2", 64'(b0.rd_data[DW +: DW]), 64'h22);
    step();

    // Same-address conflict: ALU wins.
    set_wr(0, 5, 32'hAAAA); set_wr(1, 5, 32'h5555); step(); idle();
    set_rd(0, 5); #1;
    chk("conflict_r5", 64'(b0.rd_data[DW-1:0]), 64'hAAAA);
    step();

    // Bypass versus stored value.
    set_rd(0, 4); set_wr(0, 4, 32'h1234); #1;
    chk("byp_data", 64'(b1.rd_data[DW-1:0]), 64'h1234);
    chk("byp_ready", 64'(b1.rd_ready[0]), 64'h1);
    chk("nobyp_old", 64'(b0.rd_data[DW-1:0]), 64'h0);
    step(); idle();

    // Scoreboard reserve / clear / reserve+write.
    rsv_en = 1'b1; rsv_addr = 3'd6; step(); idle();
    set_rd(2, 6); #1;
    chk("sb_pend6", 64'(b1.pending[6]), 64'h1);
    chk("sb_cnt1", 64'(b1.pending_cnt), 64'h1);
    chk("sb_rdy6", 64'(b0.rd_ready[2]), 64'h0);
    set_wr(1, 6, 32'h77); step(); idle(); #1;
    chk("sb_clr6", 64'(b1.pending[6]), 64'h0);
    chk("sb_cnt0", 64'(b1.pending_cnt), 64'h0);
    chk("sb_r6", 64'(b0.rd_data[2*DW +: DW]), 64'h77);
    rsv_en = 1'b1; rsv_addr = 3'd6; set_wr(0, 6, 32'h99); step(); idle(); #1;
    chk("sb_rsvwr_pend", 64'(b1.pending[6]), 64'h1);
    chk("sb_rsvwr_data", 64'(b0.rd_data[2*DW +: DW]), 64'h99);
    chk("sb_rsvwr_err", 64'(b1.err_dbl_rsv), 64'h0);
    step();

    // Double reserve sets sticky error until reset.
    rsv_en = 1'b1; rsv_addr = 3'd2; step();
    rsv_en = 1'b1; rsv_addr = 3'd2; step(); idle(); #1;
    chk("dbl_err", 64'(b1.err_dbl_rsv), 64'h1);
    step(); step(); #1;
    chk("dbl_sticky", 64'(b1.err_dbl_rsv), 64'h1);
    rst_n = 1'b0; step(); rst_n = 1'b1; #1;
    chk("dbl_rst", 64'(b1.err_dbl_rsv), 64'h0);
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst_n    = ($urandom_range(0, 59) != 0);
      wr_en    = 2'($urandom);
      wr_addr  = (2*AW)'($urandom);
      wr_data  = {$urandom, $urandom};
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = AW'($urandom);
      rd_addr  = (ND*AW)'($urandom);
      if ($urandom_range(0, 3) == 0) rd_addr[AW-1:0] = wr_addr[AW-1:0];
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
